video_writer: RTL and testbench

VIDEO_WRITER -- requirements
Module: video_writer

---
 rtl/video_writer.sv | 195 +++++++++++++++++++
 tb/tb_video_writer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_writer.sv
// Text-mode video memory writer: cursor-addressed character writes plus
// whole-screen fill and single-row clear, one cell per clock.

`ifndef TEXTCOLS_CHAR
`define TEXTCOLS_CHAR 80
`endif
`ifndef TEXTROWS_CHAR
`define TEXTROWS_CHAR 30
`endif
`ifndef TEXTCOLS_RANGE
`define TEXTCOLS_RANGE [6:0]
`endif
`ifndef TEXTROWS_RANGE
`define TEXTROWS_RANGE [4:0]
`endif
`ifndef CHARATTR_RANGE
`define CHARATTR_RANGE [15:0]
`endif

module video_writer #(
  parameter int COLS = `TEXTCOLS_CHAR,
  parameter int ROWS = `TEXTROWS_CHAR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic `TEXTCOLS_RANGE cmd_x,
  input  logic `TEXTROWS_RANGE cmd_y,
  input  logic `CHARATTR_RANGE cmd_value,
  input  logic `CHARATTR_RANGE cmd_mask,
  output logic                 cmd_error,
  output logic                 busy,
  output logic `TEXTCOLS_RANGE cursor_x,
  output logic `TEXTROWS_RANGE cursor_y,
  output logic                 video_write,
  output logic [15:0]          video_address,
  output logic `CHARATTR_RANGE video_value,
  output logic `CHARATTR_RANGE video_mask
);

  typedef logic `TEXTCOLS_RANGE col_t;
  typedef logic `TEXTROWS_RANGE row_t;
  typedef logic `CHARATTR_RANGE word_t;

  typedef enum logic [0:0] {StIdle, StFill} state_t;

  localparam logic [2:0] OpNop      = 3'd0;
  localparam logic [2:0] OpSetpos   = 3'd1;
  localparam logic [2:0] OpPutchar  = 3'd2;
  localparam logic [2:0] OpFill     = 3'd3;
  localparam logic [2:0] OpClearRow = 3'd4;

  localparam logic [15:0] CellsLast = 16'(COLS * ROWS - 1);
  localparam logic [15:0] ColsW     = 16'(COLS);
  localparam col_t        XLast     = col_t'(COLS - 1);
  localparam row_t        YLast     = row_t'(ROWS - 1);

  state_t      state_q, state_d;
  col_t        cursor_x_q, cursor_x_d;
  row_t        cursor_y_q, cursor_y_d;
  logic [15:0] cur_addr_q, cur_addr_d;
  logic [15:0] fill_end_q, fill_end_d;
  logic        write_q, write_d;
  logic [15:0] vaddr_q, vaddr_d;
  word_t       vvalue_q, vvalue_d;
  word_t       vmask_q, vmask_d;
  logic        error_q, error_d;
  logic [15:0] row_start;
  logic [15:0] setpos_addr;

  // Start of the cursor's row, derived from the address counter rather than y*COLS.
  assign row_start = cur_addr_q - 16'(cursor_x_q);

  // Constant-coefficient product, only used to reload the counter on SETPOS.
  assign setpos_addr = 16'(int'(cmd_y) * COLS + int'(cmd_x));

  assign cmd_ready     = (state_q == StIdle);
  assign busy          = (state_q == StFill);
  assign cursor_x      = cursor_x_q;
  assign cursor_y      = cursor_y_q;
  assign cmd_error     = error_q;
  assign video_write   = write_q;
  assign video_address = vaddr_q;
  assign video_value   = vvalue_q;
  assign video_mask    = vmask_q;

  // Next-state: command decode in IDLE, address sweep in FILL.
  always_comb begin
    state_d    = state_q;
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    cur_addr_d = cur_addr_q;
    fill_end_d = fill_end_q;
    write_d    = 1'b0;
    vaddr_d    = vaddr_q;
    vvalue_d   = vvalue_q;
    vmask_d    = vmask_q;
    error_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          case (cmd_op)
            OpNop: ;
            OpSetpos: begin
              if (int'(cmd_x) < COLS && int'(cmd_y) < ROWS) begin
                cursor_x_d = cmd_x;
                cursor_y_d = cmd_y;
                cur_addr_d = setpos_addr;
              end else begin
                error_d = 1'b1;
              end
            end
            OpPutchar: begin
              write_d  = 1'b1;
              vaddr_d  = cur_addr_q;
              vvalue_d = cmd_value;
              vmask_d  = cmd_mask;
              // Row-major layout: every advance is +1 except the full-screen wrap.
              if (cursor_x_q == XLast) begin
                cursor_x_d = '0;
                if (cursor_y_q == YLast) begin
                  cursor_y_d = '0;
                  cur_addr_d = '0;
                end else begin
                  cursor_y_d = cursor_y_q + row_t'(1);
                  cur_addr_d = cur_addr_q + 16'd1;
                end
              end else begin
                cursor_x_d = cursor_x_q + col_t'(1);
                cur_addr_d = cur_addr_q + 16'd1;
              end
            end
            OpFill: begin
              state_d    = StFill;
              write_d    = 1'b1;
              vaddr_d    = '0;
              vvalue_d   = cmd_value;
              vmask_d    = cmd_mask;
              fill_end_d = CellsLast;
            end
            OpClearRow: begin
              state_d    = StFill;
              write_d    = 1'b1;
              vaddr_d    = row_start;
              vvalue_d   = cmd_value;
              vmask_d    = cmd_mask;
              fill_end_d = row_start + ColsW - 16'd1;
            end
            default: error_d = 1'b1;
          endcase
        end
      end
      StFill: begin
        // The first cell was issued at acceptance; value/mask stay latched in the output regs.
        if (vaddr_q == fill_end_q) begin
          state_d = StIdle;
        end else begin
          write_d = 1'b1;
          vaddr_d = vaddr_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cursor_x_q <= '0;
      cursor_y_q <= '0;
      cur_addr_q <= '0;
      fill_end_q <= '0;
      write_q    <= 1'b0;
      vaddr_q    <= '0;
      vvalue_q   <= '0;
      vmask_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      cur_addr_q <= cur_addr_d;
      fill_end_q <= fill_end_d;
      write_q    <= write_d;
      vaddr_q    <= vaddr_d;
      vvalue_q   <= vvalue_d;
      vmask_q    <= vmask_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_video_writer.sv
// Directed bench for video_writer at COLS=4, ROWS=3.

`ifndef TEXTCOLS_RANGE
`define TEXTCOLS_RANGE [6:0]
`endif
`ifndef TEXTROWS_RANGE
`define TEXTROWS_RANGE [4:0]
`endif
`ifndef CHARATTR_RANGE
`define CHARATTR_RANGE [15:0]
`endif

module tb_video_writer;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_op;
  logic `TEXTCOLS_RANGE cmd_x;
  logic `TEXTROWS_RANGE cmd_y;
  logic `CHARATTR_RANGE cmd_value;
  logic `CHARATTR_RANGE cmd_mask;
  logic                 cmd_error;
  logic                 busy;
  logic `TEXTCOLS_RANGE cursor_x;
  logic `TEXTROWS_RANGE cursor_y;
  logic                 video_write;
  logic [15:0]          video_address;
  logic `CHARATTR_RANGE video_value;
  logic `CHARATTR_RANGE video_mask;

  int tests = 0;
  int fails = 0;

  video_writer #(.COLS(4), .ROWS(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_x         (cmd_x),
    .cmd_y         (cmd_y),
    .cmd_value     (cmd_value),
    .cmd_mask      (cmd_mask),
    .cmd_error     (cmd_error),
    .busy          (busy),
    .cursor_x      (cursor_x),
    .cursor_y      (cursor_y),
    .video_write   (video_write),
    .video_address (video_address),
    .video_value   (video_value),
    .video_mask    (video_mask)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1ns before inputs change or outputs are sampled.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [2:0] op, input logic [6:0] x, input logic [4:0] y,
                     input logic [15:0] val, input logic [15:0] msk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = x;
    cmd_y     = y;
    cmd_value = val;
    cmd_mask  = msk;
  endtask

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_value = '0;
    cmd_mask  = '0;
    #1;
    // PUTCHAR presented during reset must be ignored.
    cmd(3'd2, 7'd0, 5'd0, 16'h0077, 16'hffff);
    cyc();
    cyc();
    cmd_valid = 1'b0;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_write", video_write, 0);
    chk("rst_addr", video_address, 0);
    chk("rst_value", video_value, 0);
    chk("rst_mask", video_mask, 0);
    chk("rst_cx", cursor_x, 0);
    chk("rst_cy", cursor_y, 0);
    chk("rst_err", cmd_error, 0);
    reset = 1'b1;
    cyc();
    chk("idle_write", video_write, 0);

    // First PUTCHAR after reset.
    cmd(3'd2, 7'd0, 5'd0, 16'h0041, 16'hffff);
    cyc();
    cmd_valid = 1'b0;
    chk("put1_write", video_write, 1);
    chk("put1_addr", video_address, 0);
    chk("put1_value", video_value, 16'h0041);
    chk("put1_mask", video_mask, 16'hffff);
    chk("put1_cx", cursor_x, 1);
    chk("put1_cy", cursor_y, 0);
    cyc();
    chk("put1_idle_write", video_write, 0);
    chk("put1_hold_value", video_value, 16'h0041);

    // SETPOS to the last cell, then two PUTCHARs wrapping the whole screen.
    cmd(3'd1, 7'd3, 5'd2, 16'h0, 16'h0);
    cyc();
    chk("setpos_cx", cursor_x, 3);
    chk("setpos_cy", cursor_y, 2);
    chk("setpos_write", video_write, 0);
    cmd(3'd2, 7'd0, 5'd0, 16'h0042, 16'h00ff);
    cyc();
    chk("put2_write", video_write, 1);
    chk("put2_addr", video_address, 11);
    chk("put2_cx", cursor_x, 0);
    chk("put2_cy", cursor_y, 0);
    cmd(3'd2, 7'd0, 5'd0, 16'h0043, 16'h00ff);
    cyc();
    cmd_valid = 1'b0;
    chk("put3_write", video_write, 1);
    chk("put3_addr", video_address, 0);
    chk("put3_value", video_value, 16'h0043);
    chk("put3_cx", cursor_x, 1);
    chk("put3_cy", cursor_y, 0);

    // Out-of-range SETPOS on x and on y.
    cmd(3'd1, 7'd4, 5'd0, 16'h0, 16'h0);
    cyc();
    cmd_valid = 1'b0;
    chk("badx_err", cmd_error, 1);
    chk("badx_cx", cursor_x, 1);
    chk("badx_write", video_write, 0);
    cyc();
    chk("badx_err_clr", cmd_error, 0);
    cmd(3'd1, 7'd0, 5'd3, 16'h0, 16'h0);
    cyc();
    cmd_valid = 1'b0;
    chk("bady_err", cmd_error, 1);
    chk("bady_cy", cursor_y, 0);

    // Undefined op and NOP.
    cmd(3'd6, 7'd0, 5'd0, 16'h1234, 16'hffff);
    cyc();
    chk("undef_err", cmd_error, 1);
    chk("undef_write", video_write, 0);
    chk("undef_cx", cursor_x, 1);
    cmd(3'd0, 7'd0, 5'd0, 16'h1234, 16'hffff);
    cyc();
    cmd_valid = 1'b0;
    chk("nop_err", cmd_error, 0);
    chk("nop_write", video_write, 0);
    chk("nop_value", video_value, 16'h0043);

    // FILL with a PUTCHAR held pending for the whole sweep.
    cmd(3'd3, 7'd0, 5'd0, 16'h0020, 16'h00ff);
    cyc();
    cmd(3'd2, 7'd0, 5'd0, 16'h0055, 16'hffff);
    for (int i = 0; i < 12; i++) begin
      chk("fill_busy", busy, 1);
      chk("fill_ready", cmd_ready, 0);
      chk("fill_write", video_write, 1);
      chk("fill_addr", video_address, i);
      chk("fill_value", video_value, 16'h0020);
      chk("fill_mask", video_mask, 16'h00ff);
      cyc();
    end
    chk("fill_done_write", video_write, 0);
    chk("fill_done_ready", cmd_ready, 1);
    chk("fill_cx", cursor_x, 1);
    chk("fill_cy", cursor_y, 0);
    cyc();
    cmd_valid = 1'b0;
    chk("held_put_write", video_write, 1);
    chk("held_put_addr", video_address, 1);
    chk("held_put_value", video_value, 16'h0055);
    chk("held_put_cx", cursor_x, 2);

    // CLEAR_ROW on row 1.
    cmd(3'd1, 7'd2, 5'd1, 16'h0, 16'h0);
    cyc();
    chk("setpos21_cx", cursor_x, 2);
    chk("setpos21_cy", cursor_y, 1);
    cmd(3'd4, 7'd0, 5'd0, 16'h0000, 16'hffff);
    cyc();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("clr_busy", busy, 1);
      chk("clr_write", video_write, 1);
      chk("clr_addr", video_address, 4 + i);
      chk("clr_value", video_value, 16'h0000);
      cyc();
    end
    chk("clr_done_write", video_write, 0);
    chk("clr_done_ready", cmd_ready, 1);
    chk("clr_hold_addr", video_address, 7);
    chk("clr_cx", cursor_x, 2);
    chk("clr_cy", cursor_y, 1);
    cyc();
    chk("clr_idle_write", video_write, 0);

    // Reset during the 5th write cycle of FILL.
    cmd(3'd3, 7'd0, 5'd0, 16'h002e, 16'hffff);
    cyc();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("abort_write", video_write, 1);
      chk("abort_addr", video_address, i);
      if (i == 4) reset = 1'b0;
      cyc();
    end
    chk("abort_write_off", video_write, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_cx", cursor_x, 0);
    chk("abort_cy", cursor_y, 0);
    chk("abort_addr_rst", video_address, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("abort_no_write", video_write, 0);
      chk("abort_stay_idle", busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
